// File: rtl/age_matrix_pkg.sv
// Shared types and helpers for the age-matrix controller: query FSM states
// and a lowest-set-bit search used by allocation, column drain and scan.
package age_matrix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  localparam int LSB_MAX_W = 64;

  // Index of the lowest set bit; 0 when nothing is set (callers use an any flag).
  function automatic int lsb_index(input logic [LSB_MAX_W-1:0] vec);
    int idx;
    idx = 0;
    for (int i = LSB_MAX_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/age_matrix_prio_enc_lsb.sv
// Lowest-set-bit encoder with an any-set flag; W must not exceed LSB_MAX_W.
module prio_enc_lsb
  import age_matrix_pkg::*;
#(
  parameter int W = 8,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any
);

  assign any = |vec;
  assign idx = IW'(lsb_index(LSB_MAX_W'(vec)));

endmodule

// File: rtl/age_matrix_ctrl.sv
// Issue-queue age-matrix controller: slot allocation, deferred column clears
// and sequential oldest-entry scan. Optional flush port: AGE_MATRIX_CTRL_FLUSH_EN.
module age_matrix_ctrl
  import age_matrix_pkg::*;
#(
  parameter int N_ENTRIES = 8,
  localparam int ID_WIDTH = $clog2(N_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst_aL,
`ifdef AGE_MATRIX_CTRL_FLUSH_EN
  input  logic                 flush,
`endif
  input  logic                 alloc_req,
  output logic                 alloc_gnt,
  output logic [ID_WIDTH-1:0]  alloc_id,
  input  logic                 dealloc_en,
  input  logic [ID_WIDTH-1:0]  dealloc_id,
  input  logic                 query_req,
  output logic                 query_busy,
  output logic                 query_done,
  output logic                 query_empty,
  output logic [ID_WIDTH-1:0]  query_id,
  output logic [N_ENTRIES-1:0] valid_vec,
  output logic [ID_WIDTH-1:0]  row_rd_addr,
  input  logic [N_ENTRIES-1:0] row_rd_data,
  output logic                 row_wr_en,
  output logic [ID_WIDTH-1:0]  row_wr_addr,
  output logic [N_ENTRIES-1:0] row_wr_data,
  output logic                 col_wr_en,
  output logic [ID_WIDTH-1:0]  col_wr_addr,
  output logic [N_ENTRIES-1:0] col_wr_data
);

  logic                 flush_now;
  logic [N_ENTRIES-1:0] valid_reg, valid_next, pend_reg, pend_next;
  logic [N_ENTRIES-1:0] free_vec, dealloc_onehot, alloc_onehot, drain_onehot;
  logic [N_ENTRIES-1:0] above_idx, scan_src;
  logic [ID_WIDTH-1:0]  free_idx, pend_idx, scan_idx, wrap_idx;
  logic                 free_any, pend_any, scan_any, dealloc_ok;
  scan_state_t          state_reg, state_next;
  logic [ID_WIDTH-1:0]  idx_reg, idx_next, qid_reg, qid_next;
  logic                 empty_reg, empty_next;

`ifdef AGE_MATRIX_CTRL_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  assign free_vec = ~(valid_reg | pend_reg);

  prio_enc_lsb #(.W(N_ENTRIES)) u_alloc_enc (.vec(free_vec), .idx(free_idx), .any(free_any));
  prio_enc_lsb #(.W(N_ENTRIES)) u_drain_enc (.vec(pend_reg), .idx(pend_idx), .any(pend_any));
  prio_enc_lsb #(.W(N_ENTRIES)) u_scan_enc  (.vec(scan_src), .idx(scan_idx), .any(scan_any));

  // Write enables are gated by reset so the RAM sees no writes while held.
  assign alloc_gnt   = rst_aL & alloc_req & free_any & ~flush_now;
  assign alloc_id    = free_idx;
  assign dealloc_ok  = dealloc_en & valid_reg[dealloc_id] & ~flush_now;

  assign row_wr_en   = alloc_gnt;
  assign row_wr_addr = alloc_gnt ? free_idx : '0;
  assign row_wr_data = alloc_gnt ? (valid_reg & ~dealloc_onehot) : '0;

  assign col_wr_en   = rst_aL & ~alloc_gnt & pend_any;
  assign col_wr_addr = col_wr_en ? pend_idx : '0;
  assign col_wr_data = '0;

  assign valid_vec   = valid_reg;
  assign query_busy  = (state_reg == SCAN);
  assign query_done  = (state_reg == DONE);
  assign query_empty = empty_reg;
  assign query_id    = qid_reg;
  assign row_rd_addr = (state_reg == SCAN) ? idx_reg : '0;

  genvar gi;
  generate
    for (gi = 0; gi < N_ENTRIES; gi++) begin : g_bits
      assign dealloc_onehot[gi] = dealloc_en && (dealloc_id == ID_WIDTH'(gi));
      assign alloc_onehot[gi]   = alloc_gnt && (free_idx == ID_WIDTH'(gi));
      assign drain_onehot[gi]   = col_wr_en && (pend_idx == ID_WIDTH'(gi));
      assign above_idx[gi]      = (ID_WIDTH'(gi) > idx_reg);
    end
  endgenerate

  always_comb begin
    valid_next = valid_reg;
    pend_next  = pend_reg & ~drain_onehot;
    if (flush_now) begin
      pend_next  = pend_next | valid_reg;
      valid_next = '0;
    end else begin
      valid_next = valid_reg | alloc_onehot;
      if (dealloc_ok) begin
        valid_next = valid_next & ~dealloc_onehot;
        pend_next  = pend_next | dealloc_onehot;
      end
    end
  end

  // The scan encoder looks at the whole vector at start/restart, otherwise
  // only at entries above the current index.
  always_comb begin
    scan_src = valid_reg;
    if (state_reg == SCAN) begin
      scan_src = dealloc_en ? valid_next : (valid_reg & above_idx);
    end
  end

  assign wrap_idx = ID_WIDTH'(lsb_index(LSB_MAX_W'(valid_reg)));

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    qid_next   = qid_reg;
    empty_next = empty_reg;
    case (state_reg)
      IDLE: begin
        if (query_req) begin
          if (valid_reg == '0) begin
            state_next = DONE;
            empty_next = 1'b1;
          end else begin
            state_next = SCAN;
            idx_next   = scan_idx;
            empty_next = 1'b0;
          end
        end
      end
      SCAN: begin
        if (dealloc_en) begin
          if (!scan_any) begin
            state_next = DONE;
            empty_next = 1'b1;
          end else begin
            idx_next = scan_idx;
          end
        end else if ((row_rd_data & valid_reg) == '0) begin
          qid_next   = idx_reg;
          empty_next = 1'b0;
          state_next = DONE;
        end else begin
          // Wrap only guards against an inconsistent matrix; normally unreachable.
          idx_next = scan_any ? scan_idx : wrap_idx;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush_now) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      valid_reg <= '0;
      pend_reg  <= '0;
      state_reg <= IDLE;
      idx_reg   <= '0;
      qid_reg   <= '0;
      empty_reg <= 1'b0;
    end else begin
      valid_reg <= valid_next;
      pend_reg  <= pend_next;
      state_reg <= state_next;
      idx_reg   <= idx_next;
      qid_reg   <= qid_next;
      empty_reg <= empty_next;
    end
  end

endmodule

// File: doc/age_matrix_ctrl.md
Name: age_matrix_ctrl

Overview:
- Controller directly upstream of the N×N age-matrix RAM in the issue queue; owns the entry valid vector and slot allocation.
- Drives every RAM write: a row write on allocate, a deferred column clear on deallocate. Row and column writes are never issued in the same cycle.
- Answers oldest-valid-entry queries with a sequential row scan through the RAM's single row read port.
- Matrix convention: bit [i][j]=1 means entry j is older than entry i.

Parameters:
- N_ENTRIES, 8, number of queue entries; the RAM is N_ENTRIES×N_ENTRIES.
- ID_WIDTH, $clog2(N_ENTRIES), localparam, width of an entry index.

Ports:
- clk  in  1  clock
- rst_aL  in  1  asynchronous active-low reset
- alloc_req  in  1  request one new entry
- alloc_gnt  out  1  allocation granted this cycle (combinational)
- alloc_id  out  ID_WIDTH  granted slot; meaningful only when alloc_gnt=1
- dealloc_en  in  1  free entry dealloc_id
- dealloc_id  in  ID_WIDTH  entry to free
- query_req  in  1  start an oldest-entry search
- query_busy  out  1  scan in progress
- query_done  out  1  one-cycle pulse when the result is valid
- query_empty  out  1  no valid entries; qualified by query_done
- query_id  out  ID_WIDTH  oldest valid entry; qualified by query_done and !query_empty
- valid_vec  out  N_ENTRIES  current valid entries
- row_rd_addr  out  ID_WIDTH  to RAM
- row_rd_data  in  N_ENTRIES  from RAM
- row_wr_en, row_wr_addr, row_wr_data  out  1/ID_WIDTH/N_ENTRIES  to RAM
- col_wr_en, col_wr_addr, col_wr_data  out  1/ID_WIDTH/N_ENTRIES  to RAM

Behaviour:
- Reset values: valid=0, pending_clr=0, FSM in IDLE, and every output 0. All RAM write enables are deasserted in reset.
- A slot is free when it is neither valid nor pending_clr. alloc_gnt = alloc_req & (any free slot). alloc_id = lowest-index free slot.
- On grant, in the same cycle:
  - row_wr_en=1, row_wr_addr=alloc_id.
  - row_wr_data = valid & ~(dealloc_en ? onehot(dealloc_id) : 0).
  - valid[alloc_id] is set at the next edge.
- Deallocate:
  - valid[dealloc_id] clears and pending_clr[dealloc_id] sets at the next edge.
  - Deallocating an entry that is not valid is ignored.
- Column-clear drain:
  - Runs in any cycle with no row write and pending_clr≠0.
  - col_wr_en=1, col_wr_addr = lowest set bit of pending_clr, col_wr_data=0.
  - That pending bit clears at the next edge.
- Row-write priority: a row write always takes the cycle, so at most one RAM write per cycle. A pending slot is not allocatable until its column is cleared.
- Allocate and deallocate in the same cycle are both honoured. A slot freed this cycle is not granted this cycle.
- Query FSM:
  - IDLE: on query_req, if valid==0 → DONE with empty=1; otherwise → SCAN with idx = lowest valid.
  - SCAN: row_rd_addr=idx. If (row_rd_data & valid)==0, latch query_id=idx → DONE. Otherwise idx advances to the next valid index.
  - Any dealloc_en in SCAN restarts from the lowest valid entry of the updated vector, or goes to DONE with empty=1 if none remain.
  - Allocations do not restart a scan.
  - DONE: query_done=1 for one cycle → IDLE. query_req while busy is ignored.
  - Worst-case latency is N_ENTRIES+1 cycles from request to done, absent restarts.
- query_busy=1 in SCAN. row_rd_addr=0 outside SCAN.
- Reset mid-operation aborts the scan; no done pulse is produced.

Optional Feature:
- Macro AGE_MATRIX_CTRL_FLUSH_EN adds input flush (1 bit).
- flush=1: at the next edge, pending_clr |= valid, valid=0, any scan aborts to IDLE with no done pulse. alloc_gnt is forced to 0 that cycle, and dealloc is ignored.
- Without the macro there is no flush port; entries leave only by deallocation.

Decomposition:
- Shared package age_matrix_pkg: the query FSM state enum (IDLE, SCAN, DONE) and a lowest-set-bit function used for allocation, the drain and the scan.
- Natural sub-module: prio_enc_lsb (N-bit lowest-set-bit encoder with an any-set flag), instantiated three times.

Test Plan (N_ENTRIES=4):
- After reset, alloc_req for 3 cycles → ids 0,1,2; rows written 0000, 0001, 0011; valid_vec=0111.
- dealloc_en id 1 with no alloc → next cycle col_wr_en addr 1, data 0; valid_vec=0101; slot 1 is not granted before the clear.
- alloc and dealloc of id 0 in the same cycle with valid=0101 → alloc_id=1 (after the clear); row_wr_data=0100; column 0 is cleared on the first cycle without a row write.
- Allocate 4 entries, then one more alloc_req → alloc_gnt=0 (full).
- Valid={0,1,2} allocated in that order, query_req → query_done after 2 cycles, query_id=0. Dealloc 0 mid-scan → scan restarts, result query_id=1.
- query_req with valid=0 → query_done next cycle with query_empty=1. With the flush macro: flush during SCAN → no done pulse, and pending columns drain over the following cycles.
